// File: rtl/tgmux_arb_pkg.sv
// rtl/tgmux_arb_pkg.sv - shared types, defaults and helpers for the TG mux arbiter
package tgmux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2,
    BREAK  = 2'd3
  } state_t;

  localparam int DEAD_CYC_DEF = 2;
  localparam int MAX_HOLD_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  // Mux select value -> one-hot requester vector {req1, req0}.
  function automatic logic [1:0] sel_to_req(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tgmux_arb_timer.sv
// rtl/tgmux_arb_timer.sv - loadable saturating down-counter with a done flag
module tgmux_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load wins over decrement; the count parks at zero once reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/tgmux2_arbiter.sv
// rtl/tgmux2_arbiter.sv - round-robin arbiter with break-before-make for a 2:1 TG mux (option: TGMUX_ARB_CNT_EN)
module tgmux2_arbiter
  import tgmux_arb_pkg::*;
#(
  parameter int DEAD_CYC = DEAD_CYC_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SEL,
`ifdef TGMUX_ARB_CNT_EN
  output logic             EN,
  output logic [CNT_W-1:0] GCNT0,
  output logic [CNT_W-1:0] GCNT1
`else
  output logic             EN
`endif
);

  // One timer width covers both the dead-time and the hold-time counts.
  localparam int TMAX = (DEAD_CYC > MAX_HOLD) ? DEAD_CYC : MAX_HOLD;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_CYC - 1);
  localparam logic [TW-1:0] HOLD_LOAD = (MAX_HOLD == 0) ? '0 : TW'(MAX_HOLD - 1);

  if ((DEAD_CYC < 1) || (CNT_W < 1)) begin : g_param_check
    $error("tgmux2_arbiter: DEAD_CYC and CNT_W must be at least 1");
  end

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic       last_q, last_d;
  logic [1:0] gnt_q, gnt_d;
  logic       en_q, en_d;
  logic [1:0] req;
  logic       win;
  logic       grant_ev;
  logic       dead_load, dead_dec, dead_done;
  logic       hold_load, hold_dec, hold_done;

  assign req = {REQ1, REQ0};

  // Dead-time counter: SEL must sit still with EN low for DEAD_CYC cycles.
  tgmux_arb_timer #(.W(TW)) u_dead (
    .clk      (CLK),
    .rst      (RST),
    .load     (dead_load),
    .load_val (DEAD_LOAD),
    .dec      (dead_dec),
    .done     (dead_done)
  );

  // Hold counter: done once the owner has held for MAX_HOLD cycles.
  tgmux_arb_timer #(.W(TW)) u_hold (
    .clk      (CLK),
    .rst      (RST),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .dec      (hold_dec),
    .done     (hold_done)
  );

  // Pick the IDLE winner: the sole requester, or on a tie the side that did not go last.
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
  end

  // Next-state and next-output logic; outputs are computed here and registered below.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    gnt_d     = 2'b00;
    en_d      = 1'b0;
    grant_ev  = 1'b0;
    dead_load = 1'b0;
    dead_dec  = 1'b0;
    hold_load = 1'b0;
    hold_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (|req) begin
          if (win == sel_q) begin
            state_d  = GRANT;
            grant_ev = 1'b1;
          end else begin
            state_d   = SETTLE;
            sel_d     = win;
            dead_load = 1'b1;
          end
        end
      end

      SETTLE: begin
        if (dead_done) begin
          if (req[sel_q]) begin
            state_d  = GRANT;
            grant_ev = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          dead_dec = 1'b1;
        end
      end

      GRANT: begin
        if (!req[sel_q]) begin
          state_d = req[~sel_q] ? BREAK : IDLE;
        end else if ((MAX_HOLD != 0) && hold_done && req[~sel_q]) begin
          state_d = BREAK;
        end else begin
          hold_dec = 1'b1;
        end
      end

      BREAK: begin
        state_d   = SETTLE;
        sel_d     = ~sel_q;
        dead_load = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == GRANT) begin
      gnt_d = sel_to_req(sel_d);
      en_d  = 1'b1;
    end

    if (grant_ev) begin
      last_d    = sel_d;
      hold_load = 1'b1;
    end
  end

  // State and registered outputs; reset parks SEL on requester 0 and lets it win the first tie.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= 2'b00;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      en_q    <= en_d;
    end
  end

  assign GNT0 = gnt_q[0];
  assign GNT1 = gnt_q[1];
  assign SEL  = sel_q;
  assign EN   = en_q;

`ifdef TGMUX_ARB_CNT_EN
  logic [CNT_W-1:0] gcnt0_q, gcnt1_q;

  // Count grant entries per requester; wraps naturally at 2^CNT_W.
  always_ff @(posedge CLK) begin
    if (RST) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else if (grant_ev) begin
      if (sel_d) begin
        gcnt1_q <= gcnt1_q + 1'b1;
      end else begin
        gcnt0_q <= gcnt0_q + 1'b1;
      end
    end
  end

  assign GCNT0 = gcnt0_q;
  assign GCNT1 = gcnt1_q;
`endif

endmodule

// File: tb/tb_tgmux2_arbiter.sv
// tb/tb_tgmux2_arbiter.sv - self-checking bench for tgmux2_arbiter (covers TGMUX_ARB_CNT_EN when defined)
module tb_tgmux2_arbiter;

  localparam int DEAD = 2;
  localparam int MAXH = 4;
  localparam int CW   = 3;

  logic CLK = 1'b0;
  logic RST, REQ0, REQ1;
  logic GNT0, GNT1, SEL, EN;
`ifdef TGMUX_ARB_CNT_EN
  logic [CW-1:0] GCNT0, GCNT1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  tgmux2_arbiter #(.DEAD_CYC(DEAD), .MAX_HOLD(MAXH), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ0  (REQ0),
    .REQ1  (REQ1),
    .GNT0  (GNT0),
    .GNT1  (GNT1),
    .SEL   (SEL),
`ifdef TGMUX_ARB_CNT_EN
    .EN    (EN),
    .GCNT0 (GCNT0),
    .GCNT1 (GCNT1)
`else
    .EN    (EN)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner / remaining settle cycles / pending break / cycles held.
  int m_sel, m_owner, m_wait, m_brk, m_held, m_last;
  int m_cnt[2];
  bit m_valid = 1'b0;
  bit m_rst_edge = 1'b0;

  function automatic void m_grant(input int x);
    m_owner  = x;
    m_held   = 0;
    m_last   = x;
    m_cnt[x] = (m_cnt[x] + 1) % (1 << CW);
  endfunction

  // Advance the model once per rising edge from the sampled inputs.
  always @(posedge CLK) begin : model
    bit r[2];
    int w;
    r[0] = REQ0;
    r[1] = REQ1;
    m_rst_edge = RST;
    if (RST) begin
      m_sel = 0; m_owner = -1; m_wait = 0; m_brk = 0; m_held = 0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_valid = 1'b1;
    end else if (m_brk != 0) begin
      m_brk  = 0;
      m_sel  = 1 - m_sel;
      m_wait = DEAD;
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0 && r[m_sel]) m_grant(m_sel);
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        if (r[1 - m_owner]) m_brk = 1;
        m_owner = -1;
      end else if (MAXH != 0 && m_held >= MAXH - 1 && r[1 - m_owner]) begin
        m_owner = -1;
        m_brk   = 1;
      end else if (m_held < MAXH) begin
        m_held++;
      end
    end else if (r[0] || r[1]) begin
      w = (r[0] && r[1]) ? (1 - m_last) : (r[1] ? 1 : 0);
      if (w == m_sel) m_grant(w);
      else begin
        m_sel  = w;
        m_wait = DEAD;
      end
    end
  end

  // Compare the DUT against the model and the safety invariants every cycle.
  always @(negedge CLK) begin : compare
    logic prev_sel, prev_en;
    if (m_valid) begin
      chk("model_gnt0", GNT0, m_owner == 0);
      chk("model_gnt1", GNT1, m_owner == 1);
      chk("model_en",   EN,   m_owner >= 0);
      chk("model_sel",  SEL,  m_sel);
`ifdef TGMUX_ARB_CNT_EN
      chk("model_gcnt0", GCNT0, m_cnt[0]);
      chk("model_gcnt1", GCNT1, m_cnt[1]);
`endif
      chk("inv_not_both", GNT0 & GNT1, 0);
      chk("inv_gnt_sel", (GNT0 & SEL) | (GNT1 & ~SEL), 0);
      if (!m_rst_edge && (SEL !== prev_sel)) chk("inv_sel_dead", {prev_en, EN}, 0);
      prev_sel = SEL;
      prev_en  = EN;
    end
  end

  int vreq[10] = '{2, 3, 1, 0, 3, 0, 1, 3, 2, 0};
  int vdur[10] = '{3, 12, 5, 3, 2, 4, 2, 9, 6, 4};

  initial begin
    int phase, side;
    RST = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_gnt0", GNT0, 0);
    chk("rst_gnt1", GNT1, 0);
    chk("rst_sel",  SEL,  0);
    chk("rst_en",   EN,   0);
`ifdef TGMUX_ARB_CNT_EN
    chk("rst_gcnt0", GCNT0, 0);
`endif

    // Both held: 4 grant cycles, 1 break, 2 settle, then the other side, repeating.
    RST = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge CLK);
      phase = (k - 1) % 7;
      side  = ((k - 1) / 7) % 2;
      chk("rr_gnt0", GNT0, (phase < 4) && (side == 0));
      chk("rr_gnt1", GNT1, (phase < 4) && (side == 1));
      chk("rr_sel",  SEL,  (phase < 5) ? side : 1 - side);
    end

    // Same-side request: one-cycle latency, SEL untouched.
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    REQ0 = 1'b1;
    @(negedge CLK);
    chk("same_gnt0", GNT0, 1);
    chk("same_en",   EN,   1);
    repeat (5) begin
      @(negedge CLK);
      chk("same_hold_gnt0", GNT0, 1);
      chk("same_hold_sel",  SEL,  0);
    end
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("same_rel_en", EN, 0);

    // Switch sides: SEL flips after 1 edge, grant DEAD_CYC edges later.
    REQ1 = 1'b1;
    @(negedge CLK);
    chk("sw_sel_a", SEL, 1);
    chk("sw_en_a",  EN,  0);
    @(negedge CLK);
    chk("sw_gnt1_b", GNT1, 0);
    @(negedge CLK);
    chk("sw_gnt1_c", GNT1, 1);
    chk("sw_en_c",   EN,   1);
    REQ1 = 1'b0;
    @(negedge CLK);
    chk("sw_rel_sel", SEL, 1);

    // Withdraw during settle: no grant pulse, count unchanged.
    REQ0 = 1'b1;
    @(negedge CLK);
    chk("wd_sel", SEL, 0);
    REQ0 = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      chk("wd_gnt0", GNT0, 0);
      chk("wd_en",   EN,   0);
    end
`ifdef TGMUX_ARB_CNT_EN
    chk("wd_gcnt0", GCNT0, 1);
    chk("wd_gcnt1", GCNT1, 1);
`endif

    // Reset in the middle of settling.
    REQ1 = 1'b1;
    @(negedge CLK);
    chk("rs_settle_sel", SEL, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0; REQ1 = 1'b0;
    chk("rs_sel", SEL, 0);
    chk("rs_en",  EN,  0);
    chk("rs_gnt1", GNT1, 0);
    @(negedge CLK);

    // Nine grants to requester 0 wrap a 3-bit counter to 1.
    repeat (9) begin
      REQ0 = 1'b1;
      @(negedge CLK);
      chk("wrap_gnt0", GNT0, 1);
      REQ0 = 1'b0;
      @(negedge CLK);
    end
`ifdef TGMUX_ARB_CNT_EN
    chk("wrap_gcnt0", GCNT0, 1);
`endif

    // Directed request table, checked by the model.
    for (int i = 0; i < 10; i++) begin
      REQ0 = vreq[i][0];
      REQ1 = vreq[i][1];
      repeat (vdur[i]) @(negedge CLK);
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
